// File: rtl/switch_egress_buffer_if.sv
// Handshake and status bundle between a switch output port, the egress buffer
// and its downstream sink. The buffer uses the slave view, the driver the master view.
interface switch_egress_buffer_if #(
  parameter int PACKET_WIDTH = 16,
  parameter int DEPTH        = 8
);
  logic                     valid_in;
  logic [PACKET_WIDTH-1:0]  pkt_in;
  logic                     flush;
  logic                     ready_in;
  logic                     valid_out;
  logic [PACKET_WIDTH-1:0]  pkt_out;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic [15:0]              drop_cnt;
  logic [15:0]              err_cnt;

  modport master (
    output valid_in, pkt_in, flush, ready_in,
    input  valid_out, pkt_out, count, full, drop_cnt, err_cnt
  );

  modport slave (
    input  valid_in, pkt_in, flush, ready_in,
    output valid_out, pkt_out, count, full, drop_cnt, err_cnt
  );
endinterface

// File: rtl/switch_egress_buffer.sv
// Egress FIFO for one switch port: filters packets by source/target, queues them
// in order, and counts overflow/flush drops and malformed packets.
module switch_egress_buffer #(
  parameter int PACKET_WIDTH = 16,
  parameter int DEPTH        = 8,
  parameter int PORT_ID      = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  switch_egress_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [PACKET_WIDTH-1:0] mem_q [DEPTH];
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  cnt_t        count_q, count_d;
  logic        valid_q, full_q;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [16:0] drop_sum, err_sum;
  logic [3:0]  src;
  logic        well_formed, pop, push;

  // Source must be exactly one-hot and the target mask must include this port.
  assign src         = bus.pkt_in[3:0];
  assign well_formed = (src != 4'b0) && ((src & (src - 4'd1)) == 4'b0)
                       && bus.pkt_in[4+PORT_ID];
  assign pop         = valid_q && bus.ready_in;

  // NOTE: every signal written here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    push     = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_sum = {1'b0, drop_cnt_q};
    err_sum  = {1'b0, err_cnt_q};

    if (bus.valid_in && !well_formed) err_sum = err_sum + 17'd1;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_sum = drop_sum + 17'(count_q) + 17'(bus.valid_in && well_formed);
    end else begin
      // A full buffer still accepts when the head leaves in the same cycle.
      push = bus.valid_in && well_formed && ((count_q < cnt_t'(DEPTH)) || pop);
      if (bus.valid_in && well_formed && !push) drop_sum = drop_sum + 17'd1;
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      if (push && !pop)      count_d = count_q + cnt_t'(1);
      else if (pop && !push) count_d = count_q - cnt_t'(1);
    end

    drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    err_cnt_d  = err_sum[16]  ? 16'hFFFF : err_sum[15:0];
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= 1'b0;
      full_q     <= 1'b0;
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= (count_d != '0);
      full_q     <= (count_d == cnt_t'(DEPTH));
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; valid_q gates every read, so stale
  // entries are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.pkt_in;
  end

  assign bus.valid_out = valid_q;
  assign bus.pkt_out   = valid_q ? mem_q[rd_ptr_q] : '0;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.drop_cnt  = drop_cnt_q;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_switch_egress_buffer.sv
// Directed bench for switch_egress_buffer at PORT_ID=2, DEPTH=8: filtering,
// FIFO order, overflow, full push-with-pop, flush and mid-burst reset.
module tb_switch_egress_buffer;
  localparam int PW  = 16;
  localparam int D   = 8;
  localparam int PID = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  switch_egress_buffer_if #(.PACKET_WIDTH(PW), .DEPTH(D)) bus ();

  switch_egress_buffer #(.PACKET_WIDTH(PW), .DEPTH(D), .PORT_ID(PID)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Well-formed for port 2: source 4'b0001, target 4'b0100, payload = i.
  function automatic logic [15:0] pkt(input int i);
    return 16'h0041 | (16'(i) << 10);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.valid_in = 1'b0;
    bus.pkt_in   = '0;
    bus.flush    = 1'b0;
    bus.ready_in = 1'b0;
    #2;
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", bus.valid_out); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", bus.full); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", bus.count); end
    checks++; if (bus.pkt_out !== 16'h0000) begin errors++; $display("FAIL rst_pkt: got %h expected 0000", bus.pkt_out); end
    checks++; if (bus.drop_cnt !== 16'd0) begin errors++; $display("FAIL rst_drop: got %0d expected 0", bus.drop_cnt); end
    checks++; if (bus.err_cnt !== 16'd0) begin errors++; $display("FAIL rst_err: got %0d expected 0", bus.err_cnt); end
    step();
    rst_n = 1'b1;
  endtask

  // First edge after release: push 0x0041 and see it delivered, then popped.
  task automatic test_single();
    bus.valid_in = 1'b1;
    bus.pkt_in   = 16'h0041;
    bus.ready_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    checks++; if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus.valid_out); end
    checks++; if (bus.pkt_out !== 16'h0041) begin errors++; $display("FAIL single_pkt: got %h expected 0041", bus.pkt_out); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", bus.count); end
    step();
    bus.ready_in = 1'b0;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL single_pop_count: got %0d expected 0", bus.count); end
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL single_pop_valid: got %b expected 0", bus.valid_out); end
  endtask

  task automatic test_overflow();
    bus.ready_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.valid_in = 1'b1;
      bus.pkt_in   = pkt(i);
      step();
    end
    bus.valid_in = 1'b0;
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", bus.count); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", bus.full); end
    checks++; if (bus.drop_cnt !== 16'd2) begin errors++; $display("FAIL ovf_drop: got %0d expected 2", bus.drop_cnt); end
    for (int s = 0; s < 3; s++) begin
      checks++; if (bus.pkt_out !== pkt(0)) begin errors++; $display("FAIL stall_stable: got %h expected %h", bus.pkt_out, pkt(0)); end
      step();
    end
    bus.ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++; if (bus.valid_out !== 1'b1 || bus.pkt_out !== pkt(k)) begin errors++; $display("FAIL drain_order[%0d]: got %b/%h expected 1/%h", k, bus.valid_out, bus.pkt_out, pkt(k)); end
      step();
    end
    bus.ready_in = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.valid_out !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("FAIL drain_empty: got count=%0d valid=%b full=%b expected 0/0/0", bus.count, bus.valid_out, bus.full); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_pkt;
    bus.ready_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.valid_in = 1'b1;
      bus.pkt_in   = pkt(i);
      step();
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fpp_full_before: got %b expected 1", bus.full); end
    bus.valid_in = 1'b1;
    bus.pkt_in   = pkt(10);
    bus.ready_in = 1'b1;
    step();
    bus.valid_in = 1'b0;
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fpp_count: got %0d expected 8", bus.count); end
    checks++; if (bus.drop_cnt !== 16'd2) begin errors++; $display("FAIL fpp_drop: got %0d expected 2", bus.drop_cnt); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b expected 1", bus.full); end
    for (int k = 0; k < 8; k++) begin
      exp_pkt = (k < 7) ? pkt(k + 1) : pkt(10);
      checks++; if (bus.pkt_out !== exp_pkt) begin errors++; $display("FAIL fpp_order[%0d]: got %h expected %h", k, bus.pkt_out, exp_pkt); end
      step();
    end
    bus.ready_in = 1'b0;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL fpp_empty: got %0d expected 0", bus.count); end
  endtask

  task automatic test_malformed();
    bus.ready_in = 1'b0;
    bus.valid_in = 1'b1;
    bus.pkt_in   = pkt(3);
    step();
    bus.pkt_in   = 16'h0043;  // two source bits set
    step();
    bus.pkt_in   = 16'h0011;  // target lacks port 2
    step();
    bus.valid_in = 1'b0;
    checks++; if (bus.err_cnt !== 16'd2) begin errors++; $display("FAIL bad_err: got %0d expected 2", bus.err_cnt); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL bad_count: got %0d expected 1", bus.count); end
    checks++; if (bus.drop_cnt !== 16'd2) begin errors++; $display("FAIL bad_drop: got %0d expected 2", bus.drop_cnt); end
    checks++; if (bus.pkt_out !== pkt(3)) begin errors++; $display("FAIL bad_head: got %h expected %h", bus.pkt_out, pkt(3)); end
    bus.ready_in = 1'b1;
    step();
    bus.ready_in = 1'b0;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL bad_pop: got %0d expected 0", bus.count); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      bus.valid_in = 1'b1;
      bus.pkt_in   = pkt(i);
      step();
    end
    checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL flush_pre: got %0d expected 5", bus.count); end
    bus.flush    = 1'b1;
    bus.pkt_in   = pkt(5);
    bus.ready_in = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;
    checks++; if (bus.count !== 4'd0 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL flush_state: got count=%0d valid=%b expected 0/0", bus.count, bus.valid_out); end
    checks++; if (bus.drop_cnt !== 16'd8) begin errors++; $display("FAIL flush_drop: got %0d expected 8", bus.drop_cnt); end
    bus.flush    = 1'b1;
    bus.valid_in = 1'b1;
    bus.pkt_in   = 16'h0043;
    step();
    bus.flush    = 1'b0;
    bus.valid_in = 1'b0;
    checks++; if (bus.err_cnt !== 16'd3 || bus.drop_cnt !== 16'd8) begin errors++; $display("FAIL flush_bad: got err=%0d drop=%0d expected 3/8", bus.err_cnt, bus.drop_cnt); end
    bus.valid_in = 1'b1;
    bus.pkt_in   = pkt(6);
    step();
    bus.valid_in = 1'b0;
    checks++; if (bus.pkt_out !== pkt(6) || bus.count !== 4'd1) begin errors++; $display("FAIL flush_after: got %h/%0d expected %h/1", bus.pkt_out, bus.count, pkt(6)); end
  endtask

  task automatic test_reset_mid();
    for (int i = 7; i < 10; i++) begin
      bus.valid_in = 1'b1;
      bus.pkt_in   = pkt(i);
      step();
    end
    bus.valid_in = 1'b0;
    checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL rmid_pre: got %0d expected 4", bus.count); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.valid_out !== 1'b0 || bus.pkt_out !== 16'h0000) begin errors++; $display("FAIL rmid_async_out: got %b/%h expected 0/0000", bus.valid_out, bus.pkt_out); end
    checks++; if (bus.count !== 4'd0 || bus.full !== 1'b0) begin errors++; $display("FAIL rmid_async_count: got %0d/%b expected 0/0", bus.count, bus.full); end
    checks++; if (bus.drop_cnt !== 16'd0 || bus.err_cnt !== 16'd0) begin errors++; $display("FAIL rmid_async_cnt: got %0d/%0d expected 0/0", bus.drop_cnt, bus.err_cnt); end
    #2;
    rst_n        = 1'b1;
    bus.valid_in = 1'b1;
    bus.pkt_in   = pkt(11);
    step();
    bus.valid_in = 1'b0;
    checks++; if (bus.valid_out !== 1'b1 || bus.pkt_out !== pkt(11)) begin errors++; $display("FAIL rmid_push: got %b/%h expected 1/%h", bus.valid_out, bus.pkt_out, pkt(11)); end
    checks++; if (bus.count !== 4'd1 || bus.drop_cnt !== 16'd0) begin errors++; $display("FAIL rmid_count: got %0d/%0d expected 1/0", bus.count, bus.drop_cnt); end
    bus.ready_in = 1'b1;
    step();
    bus.ready_in = 1'b0;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rmid_pop: got %0d expected 0", bus.count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_malformed();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
